// File: rtl/ser_frame_rx.sv
// ser_frame_rx: serial frame receiver (start, MSB-first data, optional parity, stop)
// with a one-entry valid/ready holding register and error/overflow status pulses.
module ser_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ser_in,
  input  logic              i_bit_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_par_err,
  output logic              o_frm_err,
  output logic              o_ovf,
  output logic [7:0]        o_frame_cnt
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, STOP = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
  logic              par_q, par_d, valid_q, valid_d;
  logic              par_err_q, par_err_d, frm_err_q, frm_err_d, ovf_q, ovf_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              last_bit, stop_edge, par_ok, drain, good, accept;
  assign last_bit  = bit_cnt_q == CW'(DATA_W - 1);
  assign stop_edge = i_bit_en && state_q == STOP;
  assign par_ok    = (PARITY_EN == 0) || ((^{sh_q, par_q}) == 1'(PARITY_ODD));
  assign drain     = valid_q && i_ready;
  assign good      = stop_edge && !i_ser_in && par_ok;
  // A good byte may load even when full, provided the old one leaves on this edge.
  assign accept    = good && (!valid_q || drain);
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    if (i_bit_en) begin
      case (state_q)
        IDLE: begin
          state_d   = i_ser_in ? DATA : IDLE;
          bit_cnt_d = i_ser_in ? '0 : bit_cnt_q;
        end
        DATA: begin
          sh_d      = {sh_q[DATA_W-2:0], i_ser_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = !last_bit ? DATA : (PARITY_EN != 0) ? PAR : STOP;
        end
        PAR: begin
          par_d   = i_ser_in;
          state_d = STOP;
        end
        default: state_d = IDLE;
      endcase
    end
    data_d    = accept ? sh_q : data_q;
    valid_d   = accept || (valid_q && !drain);
    fcnt_d    = fcnt_q + 8'(accept);
    ovf_d     = good && valid_q && !i_ready;
    frm_err_d = stop_edge && i_ser_in;
    par_err_d = stop_edge && !i_ser_in && !par_ok;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
      fcnt_q    <= fcnt_d;
    end
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = state_q != IDLE;
  assign o_par_err   = par_err_q;
  assign o_frm_err   = frm_err_q;
  assign o_ovf       = ovf_q;
  assign o_frame_cnt = fcnt_q;
endmodule

// File: tb/tb_ser_frame_rx.sv
// tb_ser_frame_rx: directed checks of ser_frame_rx with default parameters.
module tb_ser_frame_rx;
  logic       i_clk = 0, i_rst = 1, i_ser_in = 0, i_bit_en = 0, i_ready = 1;
  logic [7:0] o_data, o_frame_cnt;
  logic       o_valid, o_busy, o_par_err, o_frm_err, o_ovf;
  int checks = 0, errors = 0;
  ser_frame_rx dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ser_in(i_ser_in), .i_bit_en(i_bit_en),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
    .o_par_err(o_par_err), .o_frm_err(o_frm_err), .o_ovf(o_ovf),
    .o_frame_cnt(o_frame_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic b, input int gap);
    i_bit_en = 0;
    repeat (gap) begin @(posedge i_clk); #1; end
    i_ser_in = b;
    i_bit_en = 1;
    @(posedge i_clk); #1;
    i_bit_en = 0;
    i_ser_in = 0;
  endtask
  // i_ready takes value rdy just before the stop-bit edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap, input logic rdy);
    send_bit(1'b1, gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    send_bit(p, gap);
    i_ready = rdy;
    send_bit(s, gap);
  endtask
  task automatic step;
    @(posedge i_clk); #1;
  endtask
  initial begin
    repeat (2) step;
    chk("rst_data", o_data, 8'h00);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_perr", o_par_err, 0);
    chk("rst_ferr", o_frm_err, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_cnt", o_frame_cnt, 0);
    i_rst = 0;
    step;
    send_frame(8'hA5, 0, 0, 0, 1);
    chk("a5_valid", o_valid, 1);
    chk("a5_data", o_data, 8'hA5);
    chk("a5_cnt", o_frame_cnt, 1);
    chk("a5_busy", o_busy, 0);
    step;
    chk("a5_valid_fall", o_valid, 0);
    send_frame(8'hA5, 1, 0, 0, 1);
    chk("perr_pulse", o_par_err, 1);
    chk("perr_noferr", o_frm_err, 0);
    chk("perr_valid", o_valid, 0);
    chk("perr_cnt", o_frame_cnt, 1);
    step;
    chk("perr_clear", o_par_err, 0);
    send_frame(8'h3C, 0, 1, 0, 1);
    chk("ferr_pulse", o_frm_err, 1);
    chk("ferr_busy", o_busy, 0);
    chk("ferr_valid", o_valid, 0);
    step;
    chk("ferr_clear", o_frm_err, 0);
    send_frame(8'h81, 0, 0, 0, 1);
    chk("x81_data", o_data, 8'h81);
    chk("x81_valid", o_valid, 1);
    chk("x81_cnt", o_frame_cnt, 2);
    step;
    send_frame(8'h3C, 1, 1, 0, 1);
    chk("both_ferr", o_frm_err, 1);
    chk("both_perr", o_par_err, 0);
    chk("both_cnt", o_frame_cnt, 2);
    i_ready = 0;
    send_frame(8'h3C, 0, 0, 0, 0);
    chk("hold_data", o_data, 8'h3C);
    chk("hold_cnt", o_frame_cnt, 3);
    send_frame(8'hC3, 0, 0, 0, 0);
    chk("ovf_pulse", o_ovf, 1);
    chk("ovf_data", o_data, 8'h3C);
    chk("ovf_valid", o_valid, 1);
    chk("ovf_cnt", o_frame_cnt, 3);
    step;
    chk("ovf_clear", o_ovf, 0);
    chk("ovf_still_valid", o_valid, 1);
    i_ready = 1;
    step;
    chk("hs_valid", o_valid, 0);
    chk("hs_cnt", o_frame_cnt, 3);
    i_ready = 0;
    send_frame(8'h11, 0, 0, 0, 0);
    chk("x11_data", o_data, 8'h11);
    chk("x11_cnt", o_frame_cnt, 4);
    send_frame(8'h22, 0, 0, 0, 1);
    chk("same_edge_valid", o_valid, 1);
    chk("same_edge_data", o_data, 8'h22);
    chk("same_edge_cnt", o_frame_cnt, 5);
    chk("same_edge_ovf", o_ovf, 0);
    step;
    chk("same_edge_fall", o_valid, 0);
    send_frame(8'hF0, 0, 0, 2, 1);
    chk("slow_valid", o_valid, 1);
    chk("slow_data", o_data, 8'hF0);
    chk("slow_cnt", o_frame_cnt, 6);
    step;
    chk("slow_valid_fall", o_valid, 0);
    send_frame(8'hF0, 1, 0, 2, 1);
    chk("slow_perr", o_par_err, 1);
    step;
    chk("slow_perr_width", o_par_err, 0);
    i_ready = 0;
    send_frame(8'hA5, 0, 0, 0, 0);
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_cnt", o_frame_cnt, 7);
    send_bit(1, 0);
    send_bit(0, 0);
    send_bit(1, 0);
    send_bit(0, 0);
    send_bit(1, 0);
    chk("mid_busy", o_busy, 1);
    #2 i_rst = 1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_data", o_data, 8'h00);
    chk("arst_cnt", o_frame_cnt, 0);
    step;
    i_rst = 0;
    i_ready = 1;
    send_frame(8'h5A, 0, 0, 0, 1);
    chk("post_rst_data", o_data, 8'h5A);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_cnt", o_frame_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
